// File: rtl/dyn_postsub_div_pkg.sv
// Shared types and width helpers for the post-add/sub signed divider.
// Pure declarations; no clocked logic, no latency, no flow control.
package dyn_postsub_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Dividend/quotient width: one bit of growth for the add/sub, plus sign.
  function automatic int calc_w(input int sizein);
    return 2 * sizein + 2;
  endfunction

  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/dyn_postsub_div_if.sv
// Request/result bundle of dyn_postsub_div: master drives operands, slave returns q/r.
// Level handshake: start is accepted only while busy is low; done holds until the next accept.
interface dyn_postsub_div_if #(
  parameter int SIZEIN = 16
);
  import dyn_postsub_div_pkg::*;

  localparam int W = calc_w(SIZEIN);

  logic                     ce;
  logic                     start;
  logic                     subsel;
  logic signed [2*SIZEIN:0] p;
  logic signed [2*SIZEIN:0] d;
  logic signed [SIZEIN-1:0] c;
  logic                     busy;
  logic                     done;
  logic signed [W-1:0]      q;
  logic signed [SIZEIN-1:0] r;
  logic                     dbz;

  modport master (
    output ce, start, subsel, p, d, c,
    input  busy, done, q, r, dbz
  );

  modport slave (
    input  ce, start, subsel, p, d, c,
    output busy, done, q, r, dbz
  );

endinterface

// File: rtl/dyn_postsub_div_step.sv
// Unsigned restoring divider core: one shift/subtract step per enabled edge, W steps total.
// Latency W steps after load; holds everything while ce is low, no output handshake.
module udiv_step_core #(
  parameter int SIZEIN = 16,
  parameter int W      = 34,
  parameter int CW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              load,
  input  logic              step,
  input  logic [W-1:0]      dividend,
  input  logic [SIZEIN-1:0] divisor,
  output logic [W-1:0]      quo,
  output logic [SIZEIN-1:0] rem,
  output logic [CW-1:0]     count
);

  logic [SIZEIN+1:0] rem_q;
  logic [W-1:0]      quo_q;
  logic [SIZEIN-1:0] dvs_q;
  logic [CW-1:0]     cnt_q;
  logic [SIZEIN+1:0] shifted;
  logic [SIZEIN+1:0] diff;
  logic              take;

  // The partial remainder stays below the divisor, so the top bit only matters
  // as a safety term in the compare.
  always_comb begin
    shifted = {rem_q[SIZEIN:0], quo_q[W-1]};
    diff    = shifted - {2'b00, dvs_q};
    take    = rem_q[SIZEIN+1] | (shifted >= {2'b00, dvs_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (ce) begin
      if (load) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CW'(W);
      end else if (step) begin
        rem_q <= take ? diff : shifted;
        quo_q <= {quo_q[W-2:0], take};
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign quo   = quo_q;
  assign rem   = rem_q[SIZEIN-1:0];
  assign count = cnt_q;

endmodule

// File: rtl/dyn_postsub_div.sv
// Signed divide of (p -/+ d) by c, truncating toward zero; result registered on the FIX edge.
// Latency W+1 enabled edges from accept to done; start ignored while busy or in FIX.
module dyn_postsub_div
  import dyn_postsub_div_pkg::*;
#(
  parameter int SIZEIN = 16
) (
  input logic               clk,
  input logic               rst,
  dyn_postsub_div_if.slave  bus
);

  localparam int W  = calc_w(SIZEIN);
  localparam int CW = cnt_bits(W);

  state_t                   state;
  logic                     busy_q;
  logic                     done_q;
  logic                     dbz_q;
  logic signed [W-1:0]      q_q;
  logic signed [SIZEIN-1:0] r_q;
  logic                     sx;
  logic                     sc;
  logic                     czero;

  logic signed [W-1:0]      p_ext;
  logic signed [W-1:0]      d_ext;
  logic signed [W-1:0]      x;
  logic [W-1:0]             abs_x;
  logic [SIZEIN-1:0]        abs_c;
  logic                     accept;
  logic                     step;
  logic [W-1:0]             quo;
  logic [SIZEIN-1:0]        rem;
  logic [CW-1:0]            count;
  logic signed [W-1:0]      q_mag;
  logic signed [W-1:0]      q_res;
  logic signed [SIZEIN-1:0] r_mag;
  logic signed [SIZEIN-1:0] r_res;

  // W bits hold any sum/difference of two (2*SIZEIN+1)-bit values, and its magnitude unsigned.
  always_comb begin
    p_ext  = W'(bus.p);
    d_ext  = W'(bus.d);
    x      = bus.subsel ? (p_ext + d_ext) : (p_ext - d_ext);
    abs_x  = x[W-1] ? -x : x;
    abs_c  = bus.c[SIZEIN-1] ? -bus.c : bus.c;
    accept = bus.ce && bus.start && !busy_q && (state == IDLE);
    step   = bus.ce && (state == DIV);
    q_mag  = $signed(quo);
    r_mag  = $signed(rem);
    q_res  = (sx ^ sc) ? -q_mag : q_mag;
    r_res  = sx ? -r_mag : r_mag;
  end

  udiv_step_core #(
    .SIZEIN (SIZEIN),
    .W      (W),
    .CW     (CW)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ce       (bus.ce),
    .load     (accept),
    .step     (step),
    .dividend (abs_x),
    .divisor  (abs_c),
    .quo      (quo),
    .rem      (rem),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      sx     <= 1'b0;
      sc     <= 1'b0;
      czero  <= 1'b0;
    end else if (bus.ce) begin
      case (state)
        IDLE: begin
          if (accept) begin
            sx     <= x[W-1];
            sc     <= bus.c[SIZEIN-1];
            czero  <= (bus.c == '0);
            done_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= DIV;
          end
        end
        DIV: begin
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          // A zero divisor still runs the full schedule; its raw core result is discarded.
          q_q    <= czero ? '0 : q_res;
          r_q    <= czero ? '0 : r_res;
          dbz_q  <= czero;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;

endmodule
